// File: rtl/nx_node_pkg.sv
// Shared types and widths for the nx_node control slice: message types,
// control states, err bit positions and payload width helpers.
package nx_node_pkg;

  localparam int unsigned NX_INST_W = 21;
  localparam int unsigned NX_SLOTS  = 32;
  localparam int unsigned NX_IO_W   = 4;

  typedef enum logic [1:0] {
    MSG_LOAD   = 2'd0,
    MSG_SIGNAL = 2'd1
  } msg_type_e;

  typedef enum logic [1:0] {
    ST_SETUP,
    ST_WAIT,
    ST_RUN,
    ST_EMIT
  } ctrl_state_e;

  localparam int unsigned ERR_BAD_TYPE   = 0;
  localparam int unsigned ERR_LOAD_STATE = 1;
  localparam int unsigned ERR_TICK_DROP  = 2;

  function automatic int unsigned nx_step_w(input int unsigned slots);
    return $clog2(slots);
  endfunction

  function automatic int unsigned nx_idx_w(input int unsigned io_w);
    return $clog2(io_w);
  endfunction

  // {type[1:0], last, slot[STEP_W], instr[INST_W]}
  function automatic int unsigned nx_msg_w(input int unsigned inst_w, input int unsigned slots);
    return 3 + nx_step_w(slots) + inst_w;
  endfunction

  localparam int unsigned NX_STEP_W = nx_step_w(NX_SLOTS);
  localparam int unsigned NX_IDX_W  = nx_idx_w(NX_IO_W);
  localparam int unsigned NX_MSG_W  = nx_msg_w(NX_INST_W, NX_SLOTS);

endpackage

// File: rtl/nx_lowest_pick.sv
// Combinational lowest-set-bit finder: index and one-hot of the lowest set bit.
module nx_lowest_pick #(
  parameter int unsigned W     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [W-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic [W-1:0]     o_onehot
);

  logic w_found;

  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i_vec[i] && !w_found) begin
        o_idx   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  assign o_onehot = i_vec & (~i_vec + W'(1));

endmodule

// File: rtl/nx_node_control.sv
// Message-stream sequencer for nx_node_core: instruction loads, input updates,
// tick gating and output emission. Optional NX_NODE_CTRL_TICK_QUEUE_EN adds a 1-deep pending tick.
module nx_node_control
  import nx_node_pkg::*;
#(
  parameter int unsigned INST_W = NX_INST_W,
  parameter int unsigned SLOTS  = NX_SLOTS,
  parameter int unsigned IO_W   = NX_IO_W,
  parameter int unsigned STEP_W = nx_step_w(SLOTS),
  parameter int unsigned IDX_W  = nx_idx_w(IO_W),
  parameter int unsigned MSG_W  = nx_msg_w(INST_W, SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [MSG_W-1:0]  msg_in_data,
  input  logic              msg_in_valid,
  output logic              msg_in_ready,
  output logic [IDX_W:0]    msg_out_data,
  output logic              msg_out_valid,
  input  logic              msg_out_ready,
  output logic              core_tick,
  input  logic              core_in_setup,
  input  logic              core_in_wait,
  input  logic              core_in_run,
  output logic [INST_W-1:0] core_load_instr,
  output logic [STEP_W-1:0] core_load_slot,
  output logic              core_load_last,
  output logic              core_load_valid,
  output logic              core_in_value,
  output logic [IDX_W-1:0]  core_in_index,
  output logic              core_in_valid,
  input  logic [IO_W-1:0]   core_out_values,
  input  logic [IO_W-1:0]   core_out_valids,
  output logic              idle,
  output logic [2:0]        err
);

  ctrl_state_e       r_state;
  logic              r_seen_run;
  logic [IO_W-1:0]   r_mask;
  logic [IO_W-1:0]   r_vals;
  logic              r_core_tick;
  logic [INST_W-1:0] r_load_instr;
  logic [STEP_W-1:0] r_load_slot;
  logic              r_load_last;
  logic              r_load_valid;
  logic              r_in_value;
  logic [IDX_W-1:0]  r_in_index;
  logic              r_in_valid;
  logic [2:0]        r_err;

  logic [1:0]        w_type;
  logic              w_is_load;
  logic              w_is_sig;
  logic              w_is_bad;
  logic              w_busy;
  logic              w_pending;
  logic              w_busy_drop;
  logic              w_out_valid;
  logic              w_handshake;
  logic [IDX_W-1:0]  w_idx;
  logic [IO_W-1:0]   w_onehot;
  logic              w_unused;

  assign w_unused    = core_in_setup;
  assign w_type      = msg_in_data[MSG_W-1 -: 2];
  assign w_is_load   = msg_in_valid && (w_type == MSG_LOAD);
  assign w_is_sig    = msg_in_valid && (w_type == MSG_SIGNAL);
  assign w_is_bad    = msg_in_valid && w_type[1];
  assign w_busy      = (r_state == ST_RUN) || (r_state == ST_EMIT);
  assign w_out_valid = (r_state == ST_EMIT) && (r_mask != '0);
  assign w_handshake = w_out_valid && msg_out_ready;

`ifdef NX_NODE_CTRL_TICK_QUEUE_EN
  logic r_pending;

  // WAIT always launches a pending tick on its first cycle, so WAIT consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      r_pending <= 1'b0;
    end else if (tick && w_busy) begin
      r_pending <= 1'b1;
    end
  end

  assign w_pending   = r_pending;
  assign w_busy_drop = tick && w_busy && r_pending;
`else
  assign w_pending   = 1'b0;
  assign w_busy_drop = tick && w_busy;
`endif

  nx_lowest_pick #(
    .W     (IO_W),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_vec    (r_mask),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SETUP;
      r_seen_run   <= 1'b0;
      r_mask       <= '0;
      r_vals       <= '0;
      r_core_tick  <= 1'b0;
      r_load_instr <= '0;
      r_load_slot  <= '0;
      r_load_last  <= 1'b0;
      r_load_valid <= 1'b0;
      r_in_value   <= 1'b0;
      r_in_index   <= '0;
      r_in_valid   <= 1'b0;
      r_err        <= '0;
    end else begin
      r_core_tick  <= 1'b0;
      r_load_instr <= '0;
      r_load_slot  <= '0;
      r_load_last  <= 1'b0;
      r_load_valid <= 1'b0;
      r_in_value   <= 1'b0;
      r_in_index   <= '0;
      r_in_valid   <= 1'b0;
      r_err        <= '0;

      if (w_is_load) begin
        if (r_state == ST_SETUP) begin
          r_load_valid <= 1'b1;
          r_load_instr <= msg_in_data[INST_W-1:0];
          r_load_slot  <= msg_in_data[INST_W +: STEP_W];
          r_load_last  <= msg_in_data[INST_W+STEP_W];
          if (msg_in_data[INST_W+STEP_W]) begin
            r_state <= ST_WAIT;
          end
        end else begin
          r_err[ERR_LOAD_STATE] <= 1'b1;
        end
      end

      if (w_is_sig) begin
        r_in_valid <= 1'b1;
        r_in_value <= msg_in_data[0];
        r_in_index <= msg_in_data[IDX_W:1];
      end

      r_err[ERR_BAD_TYPE]  <= w_is_bad;
      r_err[ERR_TICK_DROP] <= (tick && (r_state == ST_SETUP)) || w_busy_drop ||
                              (tick && w_pending && (r_state == ST_WAIT));

      case (r_state)
        ST_WAIT: begin
          if (tick || w_pending) begin
            r_core_tick <= 1'b1;
            r_seen_run  <= 1'b0;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Completion needs a run observed first, so a stale wait flag cannot end the run.
          if (core_in_run) begin
            r_seen_run <= 1'b1;
          end
          if (r_seen_run && core_in_wait) begin
            r_mask  <= core_out_valids;
            r_vals  <= core_out_values;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (r_mask == '0) begin
            r_state <= ST_WAIT;
          end else if (w_handshake) begin
            r_mask <= r_mask & ~w_onehot;
          end
        end
        default: ;
      endcase
    end
  end

  assign msg_in_ready    = 1'b1;
  assign msg_out_valid   = w_out_valid;
  assign msg_out_data    = w_out_valid ? {w_idx, r_vals[w_idx]} : '0;
  assign core_tick       = r_core_tick;
  assign core_load_instr = r_load_instr;
  assign core_load_slot  = r_load_slot;
  assign core_load_last  = r_load_last;
  assign core_load_valid = r_load_valid;
  assign core_in_value   = r_in_value;
  assign core_in_index   = r_in_index;
  assign core_in_valid   = r_in_valid;
  assign idle            = (r_state == ST_WAIT) && !w_pending;
  assign err             = r_err;

endmodule

// File: tb/tb_nx_node_control.sv
// Directed self-checking bench for nx_node_control (default parameters);
// the bench acts as nx_node_core and as both message stream endpoints.
module tb_nx_node_control;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [28:0] msg_in_data;
  logic        msg_in_valid;
  logic        msg_in_ready;
  logic [2:0]  msg_out_data;
  logic        msg_out_valid;
  logic        msg_out_ready;
  logic        core_tick;
  logic        core_in_setup;
  logic        core_in_wait;
  logic        core_in_run;
  logic [20:0] core_load_instr;
  logic [4:0]  core_load_slot;
  logic        core_load_last;
  logic        core_load_valid;
  logic        core_in_value;
  logic [1:0]  core_in_index;
  logic        core_in_valid;
  logic [3:0]  core_out_values;
  logic [3:0]  core_out_valids;
  logic        idle;
  logic [2:0]  err;

  int n_tests = 0;
  int n_fail  = 0;

  nx_node_control dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .msg_in_data     (msg_in_data),
    .msg_in_valid    (msg_in_valid),
    .msg_in_ready    (msg_in_ready),
    .msg_out_data    (msg_out_data),
    .msg_out_valid   (msg_out_valid),
    .msg_out_ready   (msg_out_ready),
    .core_tick       (core_tick),
    .core_in_setup   (core_in_setup),
    .core_in_wait    (core_in_wait),
    .core_in_run     (core_in_run),
    .core_load_instr (core_load_instr),
    .core_load_slot  (core_load_slot),
    .core_load_last  (core_load_last),
    .core_load_valid (core_load_valid),
    .core_in_value   (core_in_value),
    .core_in_index   (core_in_index),
    .core_in_valid   (core_in_valid),
    .core_out_values (core_out_values),
    .core_out_valids (core_out_valids),
    .idle            (idle),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [28:0] mk_load(input logic last, input logic [4:0] slot, input logic [20:0] instr);
    return {2'b00, last, slot, instr};
  endfunction

  function automatic logic [28:0] mk_sig(input logic [1:0] idx, input logic v);
    return {2'b01, 24'd0, idx, v};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Core model: one cycle in run, then back to wait with the given outputs.
  task automatic core_finish(input logic [3:0] valids, input logic [3:0] values);
    core_in_run  = 1'b1;
    core_in_wait = 1'b0;
    cyc();
    core_in_run     = 1'b0;
    core_in_wait    = 1'b1;
    core_out_valids = valids;
    core_out_values = values;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    n_tests++;
    if (msg_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", msg_in_ready); end
    n_tests++;
    if ({msg_out_valid, core_tick, core_load_valid, core_in_valid, idle} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b exp 00000", {msg_out_valid, core_tick, core_load_valid, core_in_valid, idle});
    end
    n_tests++;
    if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b exp 000", err); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_setup();
    for (int s = 0; s < 3; s++) begin
      msg_in_data  = mk_load(s == 2, 5'(s), 21'h1A000 + 21'(s));
      msg_in_valid = 1'b1;
      cyc();
      n_tests++;
      if ({core_load_valid, core_load_last, core_load_slot, core_load_instr} !== {1'b1, s == 2, 5'(s), 21'h1A000 + 21'(s)}) begin
        n_fail++; $display("FAIL load_strobe%0d: got v=%b l=%b s=%0d i=%h exp v=1 l=%b s=%0d i=%h", s,
                           core_load_valid, core_load_last, core_load_slot, core_load_instr, s == 2, s, 21'h1A000 + 21'(s));
      end
      msg_in_valid = 1'b0;
      cyc();
      n_tests++;
      if (core_load_valid !== 1'b0) begin n_fail++; $display("FAIL load_pulse%0d: got %b exp 0", s, core_load_valid); end
    end
    n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL setup_to_wait_idle: got %b exp 1", idle); end
    msg_in_data  = mk_load(1'b0, 5'd3, 21'h00055);
    msg_in_valid = 1'b1;
    cyc();
    msg_in_valid = 1'b0;
    n_tests++;
    if ({err, core_load_valid} !== 4'b0100) begin
      n_fail++; $display("FAIL load_in_wait: got err=%b lv=%b exp err=010 lv=0", err, core_load_valid);
    end
    core_in_setup = 1'b0;
    core_in_wait  = 1'b1;
    cyc();
  endtask

  task automatic test_run_emit();
    msg_out_ready = 1'b1;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n_tests++;
    if ({core_tick, idle} !== 2'b10) begin n_fail++; $display("FAIL tick_launch: got tick=%b idle=%b exp tick=1 idle=0", core_tick, idle); end
    core_in_run  = 1'b1;
    core_in_wait = 1'b0;
    cyc();
    n_tests++;
    if (core_tick !== 1'b0) begin n_fail++; $display("FAIL tick_one_cycle: got %b exp 0", core_tick); end
    core_in_run     = 1'b0;
    core_in_wait    = 1'b1;
    core_out_valids = 4'b1010;
    core_out_values = 4'b1000;
    cyc();
    n_tests++;
    if ({msg_out_valid, msg_out_data} !== 4'b1_010) begin
      n_fail++; $display("FAIL emit_first: got v=%b d=%b exp v=1 d=010", msg_out_valid, msg_out_data);
    end
    cyc();
    n_tests++;
    if ({msg_out_valid, msg_out_data} !== 4'b1_111) begin
      n_fail++; $display("FAIL emit_second: got v=%b d=%b exp v=1 d=111", msg_out_valid, msg_out_data);
    end
    cyc();
    n_tests++;
    if ({msg_out_valid, idle} !== 2'b00) begin n_fail++; $display("FAIL emit_drain: got v=%b idle=%b exp 00", msg_out_valid, idle); end
    cyc();
    n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL emit_done_idle: got %b exp 1", idle); end
  endtask

  task automatic test_backpressure();
    logic held_ok;
    msg_out_ready = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    core_finish(4'b1010, 4'b1000);
    held_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({msg_out_valid, msg_out_data} !== 4'b1_010) held_ok = 1'b0;
      cyc();
    end
    n_tests++;
    if (held_ok !== 1'b1 || {msg_out_valid, msg_out_data} !== 4'b1_010) begin
      n_fail++; $display("FAIL stall_hold: got v=%b d=%b exp v=1 d=010 for 5 cycles", msg_out_valid, msg_out_data);
    end
    msg_out_ready = 1'b1;
    cyc();
    n_tests++;
    if ({msg_out_valid, msg_out_data} !== 4'b1_111) begin
      n_fail++; $display("FAIL stall_release: got v=%b d=%b exp v=1 d=111", msg_out_valid, msg_out_data);
    end
    cyc();
    cyc();
    n_tests++;
    if ({msg_out_valid, idle} !== 2'b01) begin n_fail++; $display("FAIL stall_done: got v=%b idle=%b exp 01", msg_out_valid, idle); end
  endtask

  task automatic test_tick_in_run();
    tick = 1'b1;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n_tests++;
`ifdef NX_NODE_CTRL_TICK_QUEUE_EN
    if (err !== 3'b000) begin n_fail++; $display("FAIL run_tick_queued: got err=%b exp 000", err); end
`else
    if (err !== 3'b100) begin n_fail++; $display("FAIL run_tick_drop: got err=%b exp 100", err); end
`endif
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n_tests++;
    if (err !== 3'b100) begin n_fail++; $display("FAIL run_tick_again: got err=%b exp 100", err); end
    core_finish(4'b0000, 4'b0000);
    n_tests++;
    if (msg_out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_update_valid: got %b exp 0", msg_out_valid); end
    cyc();
    n_tests++;
`ifdef NX_NODE_CTRL_TICK_QUEUE_EN
    if ({idle, core_tick} !== 2'b00) begin n_fail++; $display("FAIL wait_entry_pending: got idle=%b tick=%b exp 00", idle, core_tick); end
`else
    if ({idle, core_tick} !== 2'b10) begin n_fail++; $display("FAIL wait_entry: got idle=%b tick=%b exp 10", idle, core_tick); end
`endif
    cyc();
    n_tests++;
`ifdef NX_NODE_CTRL_TICK_QUEUE_EN
    if (core_tick !== 1'b1) begin n_fail++; $display("FAIL pending_launch: got %b exp 1", core_tick); end
    cyc();
    n_tests++;
    if (core_tick !== 1'b0) begin n_fail++; $display("FAIL pending_once: got %b exp 0", core_tick); end
    core_finish(4'b0000, 4'b0000);
    cyc();
`else
    if (core_tick !== 1'b0) begin n_fail++; $display("FAIL no_extra_tick: got %b exp 0", core_tick); end
`endif
    n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL tick_run_idle: got %b exp 1", idle); end
  endtask

  task automatic test_bad_type_signal();
    msg_in_data  = {2'b11, 27'h5A5A5A5};
    msg_in_valid = 1'b1;
    cyc();
    n_tests++;
    if ({err, core_in_valid, core_load_valid, core_tick} !== 6'b001_000) begin
      n_fail++; $display("FAIL bad_type: got err=%b iv=%b lv=%b ct=%b exp err=001 others 0", err, core_in_valid, core_load_valid, core_tick);
    end
    msg_in_data = mk_sig(2'd2, 1'b1);
    tick        = 1'b1;
    cyc();
    msg_in_valid = 1'b0;
    tick         = 1'b0;
    n_tests++;
    if ({core_in_valid, core_in_index, core_in_value, core_tick, err} !== 8'b1_10_1_1_000) begin
      n_fail++; $display("FAIL signal_with_tick: got iv=%b ix=%0d v=%b ct=%b err=%b exp iv=1 ix=2 v=1 ct=1 err=000",
                         core_in_valid, core_in_index, core_in_value, core_tick, err);
    end
    cyc();
    n_tests++;
    if (core_in_valid !== 1'b0) begin n_fail++; $display("FAIL signal_pulse: got %b exp 0", core_in_valid); end
    core_finish(4'b0000, 4'b0000);
    cyc();
  endtask

  task automatic test_reset_emit();
    logic quiet_ok;
    msg_out_ready = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    core_finish(4'b1010, 4'b1000);
    n_tests++;
    if (msg_out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_emit: got %b exp 1", msg_out_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({msg_out_valid, msg_out_data, idle, msg_in_ready} !== 6'b0_000_0_1) begin
      n_fail++; $display("FAIL async_reset: got v=%b d=%b idle=%b rdy=%b exp v=0 d=000 idle=0 rdy=1",
                         msg_out_valid, msg_out_data, idle, msg_in_ready);
    end
    cyc();
    rst_n         = 1'b1;
    msg_out_ready = 1'b1;
    quiet_ok      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (msg_out_valid !== 1'b0 || core_tick !== 1'b0 || idle !== 1'b0) quiet_ok = 1'b0;
    end
    n_tests++;
    if (quiet_ok !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_quiet: got v=%b ct=%b idle=%b exp all 0", msg_out_valid, core_tick, idle);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    tick            = 1'b0;
    msg_in_data     = '0;
    msg_in_valid    = 1'b0;
    msg_out_ready   = 1'b0;
    core_in_setup   = 1'b1;
    core_in_wait    = 1'b0;
    core_in_run     = 1'b0;
    core_out_values = '0;
    core_out_valids = '0;
    #1;
    test_reset();
    test_setup();
    test_run_emit();
    test_backpressure();
    test_tick_in_run();
    test_bad_type_signal();
    test_reset_emit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
